// File: rtl/scan_bank4way8bit_pkg.sv
// Shared widths and defaults for the four-slot scanned register bank.
// Latency: n/a (constants only).
// Backpressure: n/a.
package scan_bank4way8bit_pkg;

    localparam int SLOTS        = 4;
    localparam int SEL_W        = 2;
    localparam int DATA_W       = 8;
    localparam int PRESCALE_DEF = 4;

endpackage

// File: rtl/scan_bank4way8bit_if.sv
// Bus bundle for the scanned register bank: write/control inputs, slot outputs, scan status.
// Latency: n/a (wires only).
// Backpressure: none; the bank accepts a write or clear every cycle.
//
// Ports (master = driver of writes/control, slave = the bank):
//   enable, clr, we, waddr, wdata : control and write port into the bank
//   outA..outD                    : slot 0..3 contents toward the downstream mux data inputs
//   select, tick, frame           : scan index and per-slot / per-frame pulses
interface scan_bank4way8bit_if;
    import scan_bank4way8bit_pkg::*;

    logic              enable;
    logic              clr;
    logic              we;
    logic [SEL_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] outA;
    logic [DATA_W-1:0] outB;
    logic [DATA_W-1:0] outC;
    logic [DATA_W-1:0] outD;
    logic [SEL_W-1:0]  select;
    logic              tick;
    logic              frame;

    modport master (
        output enable, clr, we, waddr, wdata,
        input  outA, outB, outC, outD, select, tick, frame
    );

    modport slave (
        input  enable, clr, we, waddr, wdata,
        output outA, outB, outC, outD, select, tick, frame
    );

endinterface

// File: rtl/scan_bank4way8bit_reg8_we.sv
// Byte register with synchronous clear and load enable; clear wins over load.
// Latency: 1 cycle from load/clr to q.
// Backpressure: none.
//
// Ports: clk, rst_n (async active-low), clr (sync zero), load (capture d), d (byte in), q (byte out).
module reg8_we
    import scan_bank4way8bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/scan_bank4way8bit.sv
// Four-slot byte bank with a free-running slot scanner feeding a 4:1 byte mux.
// Latency: writes/clear visible on outA..outD 1 cycle after the edge; select/tick/frame registered.
// Backpressure: none; writes and clear are taken every cycle regardless of enable.
//
// Ports: clk, rst_n (async active-low); bus (slave modport) carries enable, clr, we, waddr,
// wdata in and outA..outD, select, tick, frame out. PS_W must be wide enough to hold PRESCALE-1.
module scan_bank4way8bit
    import scan_bank4way8bit_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int PS_W     = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    scan_bank4way8bit_if.slave   bus
);

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SLOTS - 1);

    logic [PS_W-1:0]  ps;
    logic [SEL_W-1:0] sel;
    logic             tick_q;
    logic             frame_q;
    logic [SLOTS-1:0] load;

    // Clear takes priority, so it also masks the per-slot load.
    always_comb begin
        load = '0;
        for (int k = 0; k < SLOTS; k++) begin
            load[k] = bus.we && (bus.waddr == SEL_W'(k)) && !bus.clr;
        end
    end

    reg8_we slot0 (.clk(clk), .rst_n(rst_n), .clr(bus.clr), .load(load[0]), .d(bus.wdata), .q(bus.outA));
    reg8_we slot1 (.clk(clk), .rst_n(rst_n), .clr(bus.clr), .load(load[1]), .d(bus.wdata), .q(bus.outB));
    reg8_we slot2 (.clk(clk), .rst_n(rst_n), .clr(bus.clr), .load(load[2]), .d(bus.wdata), .q(bus.outC));
    reg8_we slot3 (.clk(clk), .rst_n(rst_n), .clr(bus.clr), .load(load[3]), .d(bus.wdata), .q(bus.outD));

    // Prescaler and scan index. With PRESCALE=1 ps is pinned at 0, so every enabled
    // cycle is a slot boundary and tick stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps      <= '0;
            sel     <= '0;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else if (bus.enable) begin
            if (ps == PS_LAST) begin
                ps      <= '0;
                sel     <= sel + SEL_W'(1);
                tick_q  <= 1'b1;
                frame_q <= (sel == SEL_LAST);
            end else begin
                ps      <= ps + PS_W'(1);
                tick_q  <= 1'b0;
                frame_q <= 1'b0;
            end
        end else begin
            // Hold position; pulses only mark slot entry while running.
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end
    end

    assign bus.select = sel;
    assign bus.tick   = tick_q;
    assign bus.frame  = frame_q;

endmodule

// File: tb/tb_scan_bank4way8bit.sv
module tb_scan_bank4way8bit;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        logic [1:0] sel;
        logic       tick;
        logic       frame;
    } exp_t;

    localparam int P0 = 4;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t sbq[$];

    // reference state for dut0
    logic [7:0] m_slot [4];
    int         m_ps;
    logic [1:0] m_sel;
    logic       m_tick;
    logic       m_frame;

    scan_bank4way8bit_if b0 ();
    scan_bank4way8bit_if b1 ();

    scan_bank4way8bit #(.PRESCALE(P0), .PS_W(8)) dut0 (.clk(clk), .rst_n(rst0), .bus(b0));
    scan_bank4way8bit #(.PRESCALE(1),  .PS_W(8)) dut1 (.clk(clk), .rst_n(rst1), .bus(b1));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t sample0();
        return {b0.outA, b0.outB, b0.outC, b0.outD, b0.select, b0.tick, b0.frame};
    endfunction

    function automatic exp_t sample1();
        return {b1.outA, b1.outB, b1.outC, b1.outD, b1.select, b1.tick, b1.frame};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_slot[k] = 8'h00;
        m_ps = 0; m_sel = 2'd0; m_tick = 1'b0; m_frame = 1'b0;
    endtask

    // Drive one cycle into dut0, push the expected post-edge state, advance to edge+1.
    task automatic cyc(input logic en, input logic c, input logic w,
                       input logic [1:0] wa, input logic [7:0] wd);
        b0.enable = en; b0.clr = c; b0.we = w; b0.waddr = wa; b0.wdata = wd;
        if (!rst0) begin
            model_reset();
        end else begin
            if (c) begin
                for (int k = 0; k < 4; k++) m_slot[k] = 8'h00;
            end else if (w) begin
                m_slot[wa] = wd;
            end
            if (en) begin
                if (m_ps == P0 - 1) begin
                    m_ps = 0; m_tick = 1'b1; m_frame = (m_sel == 2'd3); m_sel = m_sel + 2'd1;
                end else begin
                    m_ps = m_ps + 1; m_tick = 1'b0; m_frame = 1'b0;
                end
            end else begin
                m_tick = 1'b0; m_frame = 1'b0;
            end
        end
        sbq.push_back({m_slot[0], m_slot[1], m_slot[2], m_slot[3], m_sel, m_tick, m_frame});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        exp_t g, e;
        #2;
        g = sample0(); vectors++;
        if (g !== 36'h0) begin miscompares++; $display("FAIL reset_async got=%h exp=%h", g, 36'h0); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'h5A);
            e = sbq.pop_front(); g = sample0(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL reset_hold got=%h exp=%h", g, e); end
        end
        rst0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
            e = sbq.pop_front(); g = sample0(); vectors++;
            if (g !== e || b0.select !== 2'd0) begin
                miscompares++; $display("FAIL reset_idle got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_write_clear();
        exp_t g, e;
        logic [7:0] vals [4];
        logic [7:0] seen;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 2'(k), vals[k]);
            e = sbq.pop_front(); g = sample0(); vectors++;
            case (k)
                0: seen = b0.outA;
                1: seen = b0.outB;
                2: seen = b0.outC;
                default: seen = b0.outD;
            endcase
            if (g !== e || seen !== vals[k]) begin
                miscompares++; $display("FAIL write_slot%0d got=%h exp=%h", k, g, e);
            end
        end
        cyc(1'b0, 1'b1, 1'b1, 2'd2, 8'hFF);
        e = sbq.pop_front(); g = sample0(); vectors++;
        if (g !== e || {b0.outA, b0.outB, b0.outC, b0.outD} !== 32'h0) begin
            miscompares++; $display("FAIL clr_priority got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_scan();
        exp_t g, e;
        for (int n = 1; n <= 16; n++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
            e = sbq.pop_front(); g = sample0(); vectors++;
            if (g !== e || b0.select !== 2'((n / 4) % 4) || b0.tick !== (n % 4 == 0)
                || b0.frame !== (n == 16)) begin
                miscompares++; $display("FAIL scan_c%0d got=%h exp=%h", n, g, e);
            end
        end
    endtask

    task automatic test_enable_hold();
        exp_t g, e;
        for (int n = 0; n < 6; n++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
            e = sbq.pop_front(); g = sample0(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL hold_pre got=%h exp=%h", g, e); end
        end
        for (int n = 0; n < 5; n++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
            e = sbq.pop_front(); g = sample0(); vectors++;
            if (g !== e || b0.select !== 2'd1 || b0.tick !== 1'b0) begin
                miscompares++; $display("FAIL hold_idle got=%h exp=%h", g, e);
            end
        end
        for (int n = 1; n <= 2; n++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
            e = sbq.pop_front(); g = sample0(); vectors++;
            if (g !== e || b0.tick !== (n == 2) || b0.select !== ((n == 2) ? 2'd2 : 2'd1)) begin
                miscompares++; $display("FAIL hold_resume%0d got=%h exp=%h", n, g, e);
            end
        end
    endtask

    task automatic test_write_selected();
        exp_t g, e;
        vectors++;
        if (b0.select !== 2'd2 || b0.outC !== 8'h00) begin
            miscompares++; $display("FAIL wsel_pre got=%h/%h exp=2/00", b0.select, b0.outC);
        end
        cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'hA5);
        e = sbq.pop_front(); g = sample0(); vectors++;
        if (g !== e || b0.outC !== 8'hA5 || b0.select !== 2'd2) begin
            miscompares++; $display("FAIL wsel_post got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_random();
        exp_t g, e;
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
            e = sbq.pop_front(); g = sample0(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL random_%0d got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_mid_reset();
        exp_t g, e;
        b0.enable = 1'b1; b0.we = 1'b1; b0.waddr = 2'd1; b0.wdata = 8'h77; b0.clr = 1'b0;
        #2 rst0 = 1'b0;
        model_reset();
        #1;
        g = sample0(); vectors++;
        if (g !== 36'h0) begin miscompares++; $display("FAIL midreset_async got=%h exp=%h", g, 36'h0); end
        @(posedge clk); #1;
        rst0 = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
            e = sbq.pop_front(); g = sample0(); vectors++;
            if (g !== e || b0.tick !== (n == 4) || b0.select !== ((n == 4) ? 2'd1 : 2'd0)) begin
                miscompares++; $display("FAIL midreset_c%0d got=%h exp=%h", n, g, e);
            end
        end
    endtask

    task automatic test_prescale1();
        exp_t g;
        vectors++;
        if (sample1() !== 36'h0) begin miscompares++; $display("FAIL p1_reset got=%h exp=%h", sample1(), 36'h0); end
        b1.enable = 1'b1;
        rst1 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            vectors++;
            if (b1.select !== 2'(n % 4) || b1.tick !== 1'b1 || b1.frame !== (n % 4 == 0)) begin
                miscompares++;
                $display("FAIL p1_c%0d got=sel%0d/t%b/f%b exp=sel%0d/t1/f%b",
                         n, b1.select, b1.tick, b1.frame, n % 4, (n % 4 == 0));
            end
        end
        #2 rst1 = 1'b0;
        #1;
        g = sample1(); vectors++;
        if (g !== 36'h0) begin miscompares++; $display("FAIL p1_midreset got=%h exp=%h", g, 36'h0); end
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        b0.enable = 1'b0; b0.clr = 1'b0; b0.we = 1'b0; b0.waddr = 2'd0; b0.wdata = 8'h00;
        b1.enable = 1'b0; b1.clr = 1'b0; b1.we = 1'b0; b1.waddr = 2'd0; b1.wdata = 8'h00;
        model_reset();
        test_reset();
        test_write_clear();
        test_scan();
        test_enable_hold();
        test_write_selected();
        test_random();
        test_mid_reset();
        test_prescale1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
